// File: rtl/simd_issue_arb_pkg.sv
// Shared types and constants for the SIMD issue arbiter: op field layout,
// the unit command bundle and the in-flight shadow record.
package simd_issue_arb_pkg;
  localparam int OPW      = 13;
  localparam int DW       = 68;
  localparam int OP_FN_LO = 0;
  localparam int OP_FN_HI = 5;
  localparam int OP_WSEL  = 6;
  localparam int OP_MSEL  = 7;

  localparam logic [5:0] FN_PAND = 6'h04;
  localparam logic [5:0] FN_POR  = 6'h05;
  localparam logic [5:0] FN_PXOR = 6'h06;

  localparam logic [2:0] PTYPE_SIMD = 3'd5;

  // Shadow record is sized for up to 4 ports and the 6-bit ROB index.
  localparam int SH_IDW  = 2;
  localparam int SH_TAGW = 6;

  typedef struct packed {
    logic              vld;
    logic [SH_IDW-1:0]  id;
    logic [SH_TAGW-1:0] tag;
  } simd_shadow_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } simd_cmd_t;

  function automatic logic op_is_mul(input logic [OPW-1:0] op);
    return op[OP_MSEL];
  endfunction

  function automatic logic op_is_wide(input logic [OPW-1:0] op);
    return op[OP_WSEL];
  endfunction
endpackage

// File: rtl/simd_issue_arb_if.sv
// Issue-port, SIMD-unit and result-return signals of the arbiter.
interface simd_issue_arb_if
  import simd_issue_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = SH_TAGW
);
  logic [NREQ-1:0]           req_vld;
  logic [NREQ-1:0][OPW-1:0]  req_op;
  logic [NREQ-1:0][DW-1:0]   req_A;
  logic [NREQ-1:0][DW-1:0]   req_B;
  logic [NREQ-1:0][TAGW-1:0] req_tag;
  logic [NREQ-1:0]           req_gnt;
  logic [NREQ-1:0]           cfg_mask;
  logic                      flush;
  logic                      simd_en;
  logic [OPW-1:0]            simd_op;
  logic [DW-1:0]             simd_A;
  logic [DW-1:0]             simd_B;
  logic [DW-1:0]             simd_res;
  logic [NREQ-1:0]           res_vld;
  logic [DW-1:0]             res_data;
  logic [TAGW-1:0]           res_tag;
  logic                      idle;

  modport slave (
    input  req_vld, req_op, req_A, req_B, req_tag, cfg_mask, flush, simd_res,
    output req_gnt, simd_en, simd_op, simd_A, simd_B, res_vld, res_data, res_tag, idle
  );

  modport master (
    output req_vld, req_op, req_A, req_B, req_tag, cfg_mask, flush, simd_res,
    input  req_gnt, simd_en, simd_op, simd_A, simd_B, res_vld, res_data, res_tag, idle
  );
endinterface

// File: rtl/simd_issue_arb_rr_pick.sv
// Round-robin priority picker: first set bit of elig at or after ptr, wrapping.
module simd_issue_arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0]   s;
  logic [IW-1:0] p;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    p   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract wraps the sum
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      p = s[IW-1:0];
      if (!any && elig[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end
endmodule

// File: rtl/simd_issue_arb.sv
// Shares one SIMD unit among NREQ issue ports: round-robin grant, registered
// unit drive, and a shadow pipe that returns each result to its requester.
module simd_issue_arb
  import simd_issue_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2,
  parameter int TAGW = SH_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  simd_issue_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LAT + 2);

  logic [NREQ-1:0] elig, pick_gnt, res_hit;
  logic [IW-1:0]   pick_idx, rr_ptr, ptr_nxt;
  logic            pick_any, xfer, retire;
  simd_cmd_t       cmd_q, cmd_d;
  simd_shadow_t    sh_in;
  logic            en_q;
  logic [CW-1:0]   inflight;
  logic [NREQ-1:0] res_vld_q;
  logic [DW-1:0]   res_data_q;
  logic [TAGW-1:0] res_tag_q;

  // Stage 0 is written alongside simd_en; stages 1..LAT follow the unit's
  // internal pipe, so stage LAT lines up with simd_res.
  simd_shadow_t    sh_pipe [LAT:0];

  assign elig = bus.req_vld & ~bus.cfg_mask;

  simd_issue_arb_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign bus.req_gnt = (bus.flush || !rst) ? '0 : pick_gnt;
  assign xfer        = pick_any && !bus.flush;
  assign retire      = sh_pipe[LAT].vld;

  always_comb begin
    cmd_d   = '{op: bus.req_op[pick_idx], a: bus.req_A[pick_idx], b: bus.req_B[pick_idx]};
    sh_in   = '0;
    if (xfer) begin
      sh_in.vld = 1'b1;
      sh_in.id  = SH_IDW'(pick_idx);
      sh_in.tag = SH_TAGW'(bus.req_tag[pick_idx]);
    end
    ptr_nxt = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
    res_hit = '0;
    for (int i = 0; i < NREQ; i++) res_hit[i] = (sh_pipe[LAT].id == SH_IDW'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q       <= 1'b0;
      cmd_q      <= '0;
      rr_ptr     <= '0;
      inflight   <= '0;
      res_vld_q  <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      for (int k = 0; k <= LAT; k++) sh_pipe[k] <= '0;
    end else begin
      en_q <= xfer;
      if (xfer) begin
        cmd_q  <= cmd_d;
        rr_ptr <= ptr_nxt;
      end
      sh_pipe[0] <= sh_in;
      for (int k = 1; k <= LAT; k++) sh_pipe[k] <= bus.flush ? '0 : sh_pipe[k-1];
      inflight  <= bus.flush ? '0 : inflight + CW'(xfer) - CW'(retire);
      res_vld_q <= (retire && !bus.flush) ? res_hit : '0;
      if (retire && !bus.flush) begin
        res_data_q <= bus.simd_res;
        res_tag_q  <= TAGW'(sh_pipe[LAT].tag);
      end
    end
  end

  assign bus.simd_en  = en_q;
  assign bus.simd_op  = cmd_q.op;
  assign bus.simd_A   = cmd_q.a;
  assign bus.simd_B   = cmd_q.b;
  assign bus.res_vld  = res_vld_q;
  assign bus.res_data = res_data_q;
  assign bus.res_tag  = res_tag_q;
  assign bus.idle     = (inflight == '0) && !en_q;
endmodule

// File: tb/tb_simd_issue_arb.sv
// Bench for simd_issue_arb: table of grant vectors, hand sequences for
// latency/flush/reset, then random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_simd_issue_arb;
  import simd_issue_arb_pkg::*;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int TAGW = 6;
  localparam int IW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_issue_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();
  simd_issue_arb #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [DW-1:0] unit_fn(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op[OP_FN_HI:OP_FN_LO])
      FN_PAND: return a & b;
      FN_POR:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // SIMD unit stand-in: samples the registered drive each edge, result LAT edges later
  logic [DW-1:0] u_res [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) for (int k = 0; k < LAT; k++) u_res[k] <= '0;
    else begin
      u_res[0] <= unit_fn(bus.simd_op, bus.simd_A, bus.simd_B);
      for (int k = 1; k < LAT; k++) u_res[k] <= u_res[k-1];
    end
  end
  assign bus.simd_res = u_res[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int port; logic [TAGW-1:0] tag; logic [DW-1:0] data; } exp_t;
  exp_t pend[$];
  int   m_ptr = 0;
  logic m_en  = 1'b0;
  int   checks = 0, fails = 0;

  logic [NREQ-1:0][OPW-1:0]  p_op;
  logic [NREQ-1:0][DW-1:0]   p_A, p_B;
  logic [NREQ-1:0][TAGW-1:0] p_tag;

  typedef struct { logic [NREQ-1:0] vld; logic [NREQ-1:0] mask; logic flush; logic [NREQ-1:0] gnt; } vec_t;
  vec_t vt [18];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int m_pick(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m, input int ptr);
    logic [NREQ-1:0] e;
    e = v & ~m;
    for (int k = 0; k < NREQ; k++)
      if (((e >> ((ptr + k) % NREQ)) & NREQ'(1)) != '0) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic rnd_port(input int i);
    logic [95:0] t;
    logic [31:0] w;
    t = {$urandom(), $urandom(), $urandom()}; p_A[i] = t[DW-1:0];
    t = {$urandom(), $urandom(), $urandom()}; p_B[i] = t[DW-1:0];
    w = $urandom(); p_op[i] = w[OPW-1:0];
    case (w[20:19])
      2'd0: p_op[i][OP_FN_HI:OP_FN_LO] = FN_PAND;
      2'd1: p_op[i][OP_FN_HI:OP_FN_LO] = FN_POR;
      default: ;
    endcase
    w = $urandom(); p_tag[i] = w[TAGW-1:0];
  endtask

  // One clock: drive at negedge, check against the model, advance the model
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m, input logic f,
                      output logic [NREQ-1:0] dut_g);
    int g;
    logic [IW-1:0]   gi;
    logic [NREQ-1:0] eg, ev;
    @(negedge clk);
    bus.req_vld = v; bus.cfg_mask = m; bus.flush = f;
    bus.req_op = p_op; bus.req_A = p_A; bus.req_B = p_B; bus.req_tag = p_tag;
    #1;
    g  = f ? -1 : m_pick(v, m, m_ptr);
    eg = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("gnt", 96'(bus.req_gnt), 96'(eg));
    chk("simd_en", 96'(bus.simd_en), 96'(m_en));
    ev = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = NREQ'(1) << pend[0].port;
      chk("res_tag", 96'(bus.res_tag), 96'(pend[0].tag));
      chk("res_data", 96'(bus.res_data), 96'(pend[0].data));
      void'(pend.pop_front());
    end
    chk("res_vld", 96'(bus.res_vld), 96'(ev));
    chk("idle", 96'(bus.idle), 96'(pend.size() == 0 && !m_en));
    dut_g = bus.req_gnt;
    if (f) begin
      pend.delete();
      m_en = 1'b0;
    end else if (g >= 0) begin
      gi = IW'(g);
      pend.push_back('{due: cyc + LAT + 2, port: g, tag: p_tag[gi],
                       data: unit_fn(p_op[gi], p_A[gi], p_B[gi])});
      m_ptr = (g + 1) % NREQ;
      m_en  = 1'b1;
    end else m_en = 1'b0;
    @(posedge clk);
  endtask

  // Async reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 96'(bus.req_gnt), 96'(0));
    chk("rst_simd_en", 96'(bus.simd_en), 96'(0));
    chk("rst_simd_opAB", 96'(|{bus.simd_op, bus.simd_A, bus.simd_B}), 96'(0));
    chk("rst_res_vld", 96'(bus.res_vld), 96'(0));
    chk("rst_res_data_tag", 96'(|{bus.res_data, bus.res_tag}), 96'(0));
    chk("rst_idle", 96'(bus.idle), 96'(1));
    bus.req_vld = '0; bus.cfg_mask = '0; bus.flush = 1'b0;
    pend.delete(); m_ptr = 0; m_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] g, pv, msk;
    logic fl;
    bus.req_vld = '0; bus.cfg_mask = '0; bus.flush = 1'b0;
    bus.req_op = '0; bus.req_A = '0; bus.req_B = '0; bus.req_tag = '0;
    for (int i = 0; i < NREQ; i++) rnd_port(i);

    vt[0]  = '{2'b11, 2'b00, 1'b0, 2'b01};
    vt[1]  = '{2'b11, 2'b00, 1'b0, 2'b10};
    vt[2]  = '{2'b11, 2'b00, 1'b0, 2'b01};
    vt[3]  = '{2'b11, 2'b01, 1'b0, 2'b10};
    vt[4]  = '{2'b11, 2'b01, 1'b0, 2'b10};
    vt[5]  = '{2'b11, 2'b00, 1'b0, 2'b01};
    vt[6]  = '{2'b11, 2'b00, 1'b1, 2'b00};
    vt[7]  = '{2'b11, 2'b00, 1'b0, 2'b10};
    vt[8]  = '{2'b00, 2'b00, 1'b0, 2'b00};
    vt[9]  = '{2'b10, 2'b00, 1'b0, 2'b10};
    vt[10] = '{2'b01, 2'b10, 1'b0, 2'b01};
    vt[11] = '{2'b11, 2'b11, 1'b0, 2'b00};
    vt[12] = '{2'b01, 2'b00, 1'b0, 2'b01};
    for (int i = 13; i < 18; i++) vt[i] = '{2'b00, 2'b00, 1'b0, 2'b00};

    do_reset();

    // Single pand on port 0: simd_en after the grant edge, result LAT+1 edges later
    p_op[0] = '0; p_op[0][OP_FN_HI:OP_FN_LO] = FN_PAND;
    p_A[0] = 68'hF0F0; p_B[0] = 68'hFF00; p_tag[0] = 6'd5;
    step(2'b01, 2'b00, 1'b0, g);
    chk("t1_gnt", 96'(g), 96'(2'b01));
    #1 chk("t1_simd_en", 96'(bus.simd_en), 96'(1));
    step(2'b00, 2'b00, 1'b0, g);
    #1 chk("t1_no_early_res", 96'(bus.res_vld), 96'(0));
    step(2'b00, 2'b00, 1'b0, g);
    step(2'b00, 2'b00, 1'b0, g);
    #1;
    chk("t1_res_vld", 96'(bus.res_vld), 96'(2'b01));
    chk("t1_res_tag", 96'(bus.res_tag), 96'(5));
    chk("t1_res_data", 96'(bus.res_data), 96'(68'hF000));
    for (int i = 0; i < 2; i++) step(2'b00, 2'b00, 1'b0, g);

    // Table: alternation, masking, flush blocking, single-eligible wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < NREQ; j++) rnd_port(j);
      step(vt[i].vld, vt[i].mask, vt[i].flush, g);
      chk($sformatf("tbl%0d_gnt", i), 96'(g), 96'(vt[i].gnt));
    end

    // Flush one cycle after the second issue: neither result returns
    do_reset();
    step(2'b01, 2'b00, 1'b0, g);
    step(2'b10, 2'b00, 1'b0, g);
    step(2'b11, 2'b00, 1'b1, g);
    chk("t4_gnt_flush", 96'(g), 96'(0));
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 2'b00, 1'b0, g);
      #1 chk("t4_res_vld", 96'(bus.res_vld), 96'(0));
      if (i == 1) chk("t4_idle", 96'(bus.idle), 96'(1));
    end

    // Reset with two ops in flight
    for (int j = 0; j < NREQ; j++) rnd_port(j);
    step(2'b01, 2'b00, 1'b0, g);
    step(2'b10, 2'b00, 1'b0, g);
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b0, g);
    #1 chk("t5_idle", 96'(bus.idle), 96'(1));
    step(2'b11, 2'b00, 1'b0, g);
    chk("t5_first_gnt", 96'(g), 96'(2'b01));
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b0, g);

    // Port 1 stalls behind port 0 then withdraws
    do_reset();
    step(2'b11, 2'b00, 1'b0, g);
    chk("t6_gnt", 96'(g), 96'(2'b01));
    step(2'b00, 2'b00, 1'b0, g);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b0, g);
    #1 chk("t6_idle", 96'(bus.idle), 96'(1));

    // Random traffic obeying the hold-while-waiting rule
    pv = '0; msk = '0; g = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] || g[i]) begin
          pv[i] = ($urandom_range(0, 3) != 0);
          rnd_port(i);
        end else if ($urandom_range(0, 15) == 0) pv[i] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) msk = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      fl = ($urandom_range(0, 19) == 0);
      step(pv, msk, fl, g);
    end
    for (int i = 0; i < 5; i++) step('0, '0, 1'b0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
